// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - shared op and occupancy-state encodings for the extender pipe
package ext_pkg;

    localparam logic [2:0] EXT_SEXT = 3'd0;
    localparam logic [2:0] EXT_ZEXT = 3'd1;
    localparam logic [2:0] EXT_LUI  = 3'd2;
    localparam logic [2:0] EXT_LB   = 3'd3;
    localparam logic [2:0] EXT_LBU  = 3'd4;
    localparam logic [2:0] EXT_LH   = 3'd5;
    localparam logic [2:0] EXT_LHU  = 3'd6;
    localparam logic [2:0] EXT_PASS = 3'd7;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate / load-data extender
module ext_core
    import ext_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int IMM_W  = 16,
    parameter int LANE_W = $clog2(OUT_W/8)
) (
    input  logic [2:0]        op,
    input  logic [IMM_W-1:0]  imm,
    input  logic [OUT_W-1:0]  word,
    input  logic [LANE_W-1:0] addr_lo,
    output logic [OUT_W-1:0]  data,
    output logic              misalign
);

    logic [LANE_W+2:0] w_shamt;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;

    // Little-endian: shifting the selected lane down to bit 0 yields both byte and halfword.
    assign w_shamt = {addr_lo, 3'b000};
    assign w_half  = 16'(word >> w_shamt);
    assign w_byte  = w_half[7:0];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (op)
            EXT_SEXT: data = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
            EXT_ZEXT: data = {{(OUT_W-IMM_W){1'b0}}, imm};
            EXT_LUI:  data = {imm, {(OUT_W-IMM_W){1'b0}}};
            EXT_LB:   data = {{(OUT_W-8){w_byte[7]}}, w_byte};
            EXT_LBU:  data = {{(OUT_W-8){1'b0}}, w_byte};
            // An odd offset also covers the halfword that would cross the top of the word.
            EXT_LH: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data = {{(OUT_W-16){w_half[15]}}, w_half};
            end
            EXT_LHU: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data = {{(OUT_W-16){1'b0}}, w_half};
            end
            default:  data = word;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - valid/ready extender stage with a 2-entry skid buffer
module ext_pipe
    import ext_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int IMM_W  = 16,
    parameter int LANE_W = $clog2(OUT_W/8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [OUT_W-1:0]  in_word,
    input  logic [LANE_W-1:0] in_addr_lo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_misalign
);

    logic [OUT_W-1:0] w_core_data;
    logic             w_core_mis;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [1:0]       w_next_state;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_mis;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_skid_mis;

    ext_core #(
        .OUT_W (OUT_W),
        .IMM_W (IMM_W)
    ) u_core (
        .op       (in_op),
        .imm      (in_imm),
        .word     (in_word),
        .addr_lo  (in_addr_lo),
        .data     (w_core_data),
        .misalign (w_core_mis)
    );

    assign in_ready     = r_in_ready;
    assign out_valid    = (r_state != ST_EMPTY);
    assign out_data     = r_out_data;
    assign out_misalign = r_out_mis;
    assign w_in_fire    = in_valid && r_in_ready;
    assign w_out_fire   = out_valid && out_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_in_fire) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_in_fire && !w_out_fire)      w_next_state = ST_TWO;
                else if (!w_in_fire && w_out_fire) w_next_state = ST_EMPTY;
            end
            ST_TWO:   if (w_out_fire) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_mis   <= 1'b0;
            r_skid_data <= '0;
            r_skid_mis  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_TWO);
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_out_data <= w_core_data;
                        r_out_mis  <= w_core_mis;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_out_data <= w_core_data;
                        r_out_mis  <= w_core_mis;
                    end else if (w_in_fire) begin
                        r_skid_data <= w_core_data;
                        r_skid_mis  <= w_core_mis;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_out_data <= r_skid_data;
                        r_out_mis  <= r_skid_mis;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
